// File: rtl/serial_word_transmitter.sv
// rtl/serial_word_transmitter.sv - parallel word to serial bitstream, MSB- or LSB-first, with stall
module serial_word_transmitter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         dir,
  input  logic         fill_in,
  input  logic         hold,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic [N-1:0] shift_q,
  output logic [7:0]   frame_count
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  shift_d;
  logic [7:0]    fc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dir_q       <= 1'b0;
      shift_q     <= '0;
      frame_count <= 8'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      dir_q       <= dir_d;
      shift_q     <= shift_d;
      frame_count <= fc_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    dir_d     = dir_q;
    shift_d   = shift_q;
    fc_d      = frame_count;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = SHIFT;
          shift_d = in_data;
          dir_d   = dir;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        ser_valid = !hold;
        ser_out   = dir_q ? shift_q[0] : shift_q[N-1];
        ser_last  = !hold && (cnt == LAST);
        if (!hold) begin
          // The final bit leaves the register untouched so shift_q shows the fully-shifted word.
          if (cnt == LAST) begin
            state_d = IDLE;
            fc_d    = frame_count + 8'd1;
          end else begin
            cnt_d   = cnt + CW'(1);
            shift_d = dir_q ? {fill_in, shift_q[N-1:1]} : {shift_q[N-2:0], fill_in};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// tb/tb_serial_word_transmitter.sv - scoreboard bench for serial_word_transmitter
module tb_serial_word_transmitter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         dir;
  logic         fill_in;
  logic         hold;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic [N-1:0] shift_q;
  logic [7:0]   frame_count;

  serial_word_transmitter #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .dir(dir), .fill_in(fill_in), .hold(hold),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last),
    .shift_q(shift_q), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [1:0] exp_q[$];
  logic [7:0] exp_fc = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected serial order: bit i of the frame is w[N-1-i] MSB-first, w[i] LSB-first.
  task automatic push_frame(input logic [N-1:0] w, input logic d);
    for (int i = 0; i < N; i++)
      exp_q.push_back({(i == N - 1), (d ? w[i] : w[N-1-i])});
  endtask

  function automatic logic [N-1:0] model_shift(input logic [N-1:0] w, input logic d,
                                               input logic f, input int k);
    int unsigned full = (1 << N) - 1;
    int unsigned v = w;
    int unsigned r;
    if (!d) r = ((v << k) | (f ? ((1 << k) - 1) : 0)) & full;
    else    r = (v >> k) | (f ? (full & ~(full >> k)) : 0);
    return r[N-1:0];
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (ser_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_bit: got ser_out=%0b with no bit expected at %0t", ser_out, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("ser_out", {31'd0, ser_out}, {31'd0, e[0]});
          chk("ser_last", {31'd0, ser_last}, {31'd0, e[1]});
        end
      end else begin
        chk("ser_last_idle", {31'd0, ser_last}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_fc = 8'd0;
  endtask

  task automatic start_accept(input logic [N-1:0] w, input logic d, input logic f);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = w; dir = d; fill_in = f;
    hold = 1'($urandom_range(0, 1));
    push_frame(w, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = N'($urandom);
    dir = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input logic [N-1:0] w, input logic d, input logic f,
                           input logic [15:0] pat);
    int k = 0;
    int cycles = 0;
    int nh = 0;
    logic h;
    start_accept(w, d, f);
    for (int c = 0; c < N + 20; c++) begin
      h = (c < 16) ? pat[c] : 1'b0;
      hold = h;
      #1;
      chk("ser_valid_vs_hold", {31'd0, ser_valid}, {31'd0, !h});
      chk("busy_ready", {31'd0, in_ready}, 32'd0);
      chk("shift_q_step", {{(32-N){1'b0}}, shift_q}, {{(32-N){1'b0}}, model_shift(w, d, f, k)});
      @(posedge clk); #1;
      cycles++;
      if (h) nh++;
      else if (k < N - 1) k++;
      if (in_ready === 1'b1) break;
    end
    hold = 1'b0;
    exp_fc = exp_fc + 8'd1;
    chk("frame_cycles", cycles, N + nh);
    chk("shift_q_final", {{(32-N){1'b0}}, shift_q}, {{(32-N){1'b0}}, model_shift(w, d, f, N - 1)});
    chk("frame_count", {24'd0, frame_count}, {24'd0, exp_fc});
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; dir = 1'b0; fill_in = 1'b0; hold = 1'b0;

    // One reset edge, then reset values
    do_reset();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
    chk("rst_shift_q", {{(32-N){1'b0}}, shift_q}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);

    run_frame(4'b1011, 1'b0, 1'b0, 16'h0000);
    chk("after_msb_ready", {31'd0, in_ready}, 32'd1);
    chk("after_msb_fc", {24'd0, frame_count}, 32'd1);
    run_frame(4'b1011, 1'b1, 1'b1, 16'h0000);
    run_frame(4'b1011, 1'b0, 1'b1, 16'h0006);

    // Back-to-back words with in_valid held high and in_data changed mid-frame
    do_reset();
    begin
      int cyc = 0;
      in_valid = 1'b1; in_data = 4'b1100; dir = 1'b0; fill_in = 1'b0;
      push_frame(4'b1100, 1'b0);
      push_frame(4'b0011, 1'b0);
      @(posedge clk); #1;
      in_data = 4'b0011;
      while (in_ready !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1; cyc++;
      end
      chk("b2b_first_len", cyc, N);
      chk("b2b_idle_gap", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("b2b_second_accept", {31'd0, in_ready}, 32'd0);
      chk("b2b_second_word", {{(32-N){1'b0}}, shift_q}, 32'h3);
      in_valid = 1'b0;
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1; cyc++;
      end
      chk("b2b_fc", {24'd0, frame_count}, 32'd2);
      exp_fc = 8'd2;
    end

    // Reset two bits into a frame, with in_valid high to show reset priority
    start_accept(4'b0110, 1'b1, 1'b0);
    hold = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; in_valid = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    exp_fc = 8'd0;
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("midrst_fc", {24'd0, frame_count}, 32'd0);
    chk("midrst_shift_q", {{(32-N){1'b0}}, shift_q}, 32'd0);
    run_frame(4'b1001, 1'b0, 1'b1, 16'h0000);

    // Random frames, enough to wrap frame_count past 255
    for (int i = 0; i < 260; i++)
      run_frame(N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom & $urandom & $urandom));

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
